// File: rtl/unstriping.sv
// -----------------------------------------------------------------------------
// unstriping
//   Receive-side inverse of the two-lane striper. Words arriving on lane_0 and
//   lane_1 are buffered in small per-lane FIFOs, which absorb inter-lane skew.
//   They are merged back into a single stream on clk_2f, strictly alternating
//   lane 0, lane 1, lane 0, ...  One merged word per cycle at peak.
//
// Configuration macro:
//   UNSTRIPING_CNT_EN  when defined, adds the CNT_W parameter and the
//                      word_count output (number of words emitted, wrapping).
//
// Parameters:
//   DATA_W      word width of each lane and of data_out
//   FIFO_DEPTH  words per lane FIFO (power of two, >= 2)
//   CNT_W       width of word_count (UNSTRIPING_CNT_EN only)
//
// Ports:
//   clk_2f      in   single clock, rising edge
//   reset       in   asynchronous active-high reset; clears all state
//   lane_0      in   lane 0 word, sampled when valid_0 = 1
//   valid_0     in   lane 0 word valid
//   lane_1      in   lane 1 word, sampled when valid_1 = 1
//   valid_1     in   lane 1 word valid
//   data_out    out  merged word (registered, holds when valid_out = 0)
//   valid_out   out  data_out valid this cycle (registered)
//   overflow    out  sticky: a word was dropped on a full lane FIFO
//   word_count  out  words emitted (UNSTRIPING_CNT_EN only)
// -----------------------------------------------------------------------------
module unstriping #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
`ifdef UNSTRIPING_CNT_EN
  , parameter int CNT_W    = 16
`endif
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] lane_0,
  input  logic              valid_0,
  input  logic [DATA_W-1:0] lane_1,
  input  logic              valid_1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              overflow
`ifdef UNSTRIPING_CNT_EN
  , output logic [CNT_W-1:0] word_count
`endif
);

  localparam int             PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {
    S_L0,  // next word comes from lane 0
    S_L1   // next word comes from lane 1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DATA_W-1:0] w_lane   [2];
  logic [DATA_W-1:0] w_head   [2];
  logic [1:0]        w_valid;
  logic [1:0]        w_push;
  logic [1:0]        w_pop;
  logic [1:0]        w_full;
  logic [1:0]        w_nempty;
  logic              w_drop;

  logic [DATA_W-1:0] r_data_out;
  logic              r_valid_out;
  logic              r_overflow;

  assign w_lane[0] = lane_0;
  assign w_lane[1] = lane_1;
  assign w_valid   = {valid_1, valid_0};

  // ---------------------------------------------------------------------------
  // Per-lane FIFOs. Full/empty come from an occupancy counter (0..FIFO_DEPTH),
  // so the pointers can stay log2(FIFO_DEPTH) bits and simply wrap.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    assign w_full[g]   = (r_count == DEPTH_C);
    assign w_nempty[g] = (r_count != '0);
    assign w_head[g]   = r_mem[r_rd_ptr];
    // A full FIFO still accepts a word when its head leaves on the same edge.
    assign w_push[g]   = w_valid[g] && (!w_full[g] || w_pop[g]);

    // NOTE: storage has no reset; the reset occupancy counter is what marks
    // its contents as invalid, and leaving it out keeps it plain RAM.
    always_ff @(posedge clk_2f) begin
      if (w_push[g]) r_mem[r_wr_ptr] <= w_lane[g];
    end

    always_ff @(posedge clk_2f or posedge reset) begin
      if (reset) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push[g]) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop[g])  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push[g], w_pop[g]})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // A word is lost only when its FIFO is full and is not draining this edge.
  assign w_drop = |(w_valid & w_full & ~w_pop);

  // ---------------------------------------------------------------------------
  // Lane-select FSM. The pop decision looks only at occupancy before the edge,
  // so a word written at edge N can leave at edge N+1 at the earliest. The FSM
  // never skips a lane: a waiting lane 1 word stalls behind an empty lane 0.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) r_state <= S_L0;
    else       r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_pop        = '0;
    case (r_state)
      S_L0: if (w_nempty[0]) begin
        w_pop[0]     = 1'b1;
        w_state_next = S_L1;
      end
      S_L1: if (w_nempty[1]) begin
        w_pop[1]     = 1'b1;
        w_state_next = S_L0;
      end
      default: w_state_next = S_L0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered output stage. data_out holds its last word across idle cycles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_valid_out <= |w_pop;
      if (|w_pop)  r_data_out <= w_pop[1] ? w_head[1] : w_head[0];
      if (w_drop)  r_overflow <= 1'b1;
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign overflow  = r_overflow;

`ifdef UNSTRIPING_CNT_EN
  logic [CNT_W-1:0] r_word_count;

  // Counts every edge that raises valid_out; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset)       r_word_count <= '0;
    else if (|w_pop) r_word_count <= r_word_count + 1'b1;
  end

  assign word_count = r_word_count;
`endif

endmodule

// File: tb/tb_unstriping.sv
// -----------------------------------------------------------------------------
// tb_unstriping
//   Directed testbench for unstriping with DATA_W=32, FIFO_DEPTH=4 (and CNT_W=4
//   when UNSTRIPING_CNT_EN is defined). Inputs change 1 time unit after each
//   rising edge; outputs are checked at that same point, i.e. they show the
//   result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_unstriping;

  logic        clk_2f;
  logic        reset;
  logic [31:0] lane_0;
  logic        valid_0;
  logic [31:0] lane_1;
  logic        valid_1;
  logic [31:0] data_out;
  logic        valid_out;
  logic        overflow;
`ifdef UNSTRIPING_CNT_EN
  logic [3:0]  word_count;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  unstriping #(
    .DATA_W     (32),
    .FIFO_DEPTH (4)
`ifdef UNSTRIPING_CNT_EN
    , .CNT_W    (4)
`endif
  ) dut (
    .clk_2f     (clk_2f),
    .reset      (reset),
    .lane_0     (lane_0),
    .valid_0    (valid_0),
    .lane_1     (lane_1),
    .valid_1    (valid_1),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .overflow   (overflow)
`ifdef UNSTRIPING_CNT_EN
    , .word_count (word_count)
`endif
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drive both lanes for one edge, then stop 1 unit past that edge.
  task automatic cyc(input logic v0, input logic [31:0] d0,
                     input logic v1, input logic [31:0] d1);
    valid_0 = v0;
    lane_0  = d0;
    valid_1 = v1;
    lane_1  = d1;
    @(posedge clk_2f);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Expect one merged word this cycle.
  task automatic exp_word(input string tag, input logic [31:0] w);
    check({tag, ".vld"}, 32'(valid_out), 32'd1);
    check({tag, ".dat"}, data_out, w);
  endtask

  // Expect an idle output cycle.
  task automatic exp_none(input string tag);
    check({tag, ".vld"}, 32'(valid_out), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    valid_0 = 1'b0;
    valid_1 = 1'b0;
    lane_0  = '0;
    lane_1  = '0;

    // ---- 1: reset held three cycles, lanes idle -------------------------
    for (int i = 0; i < 3; i++) begin
      idle();
      check("rst.dat", data_out, 32'h0);
      check("rst.vld", 32'(valid_out), 32'd0);
      check("rst.ovf", 32'(overflow), 32'd0);
    end
    reset = 1'b0;

    // ---- 2: alternating lanes, 4 pairs -----------------------------------
    // Each word appears on the edge after the one that sampled it.
    cyc(1'b1, 32'hA0000001, 1'b0, 32'h0);  exp_none("alt0");
    cyc(1'b0, 32'h0, 1'b1, 32'hB0000002);  exp_word("alt1", 32'hA0000001);
    cyc(1'b1, 32'hA0000003, 1'b0, 32'h0);  exp_word("alt2", 32'hB0000002);
    cyc(1'b0, 32'h0, 1'b1, 32'hB0000004);  exp_word("alt3", 32'hA0000003);
    cyc(1'b1, 32'hA0000005, 1'b0, 32'h0);  exp_word("alt4", 32'hB0000004);
    cyc(1'b0, 32'h0, 1'b1, 32'hB0000006);  exp_word("alt5", 32'hA0000005);
    cyc(1'b1, 32'hA0000007, 1'b0, 32'h0);  exp_word("alt6", 32'hB0000006);
    cyc(1'b0, 32'h0, 1'b1, 32'hB0000008);  exp_word("alt7", 32'hA0000007);
    idle();                                exp_word("alt8", 32'hB0000008);
    idle();                                exp_none("alt9");
    check("alt9.hold", data_out, 32'hB0000008);

    // ---- 3: lane 1 leads lane 0 by one cycle -----------------------------
    cyc(1'b0, 32'h0, 1'b1, 32'h00000011);  exp_none("lead0");
    cyc(1'b1, 32'h00000022, 1'b0, 32'h0);  exp_none("lead1");
    idle();                                exp_word("lead2", 32'h00000022);
    idle();                                exp_word("lead3", 32'h00000011);
    idle();                                exp_none("lead4");

    // ---- 4: lane 0 only, fill FIFO0, pop+push on full, then overflow -----
    cyc(1'b1, 32'hC0000001, 1'b0, 32'h0);  exp_none("fill1");
    cyc(1'b1, 32'hC0000002, 1'b0, 32'h0);  exp_word("fill2", 32'hC0000001);
    cyc(1'b1, 32'hC0000003, 1'b0, 32'h0);  exp_none("fill3");
    cyc(1'b1, 32'hC0000004, 1'b0, 32'h0);  exp_none("fill4");
    cyc(1'b1, 32'hC0000005, 1'b0, 32'h0);  exp_none("fill5");
    check("fill5.ovf", 32'(overflow), 32'd0);        // FIFO0 now C2..C5, full
    cyc(1'b0, 32'h0, 1'b1, 32'hD0000001);  exp_none("fill6");
    idle();                                exp_word("fill7", 32'hD0000001);
    // FIFO0 full, but its head leaves this edge: C6 must be accepted.
    cyc(1'b1, 32'hC0000006, 1'b0, 32'h0);  exp_word("pp", 32'hC0000002);
    check("pp.ovf", 32'(overflow), 32'd0);
    // Now waiting on lane 1, FIFO0 full and not popped: C7 is dropped.
    cyc(1'b1, 32'hC0000007, 1'b0, 32'h0);  exp_none("drop");
    check("drop.ovf", 32'(overflow), 32'd1);
    cyc(1'b0, 32'h0, 1'b1, 32'hD0000002);  exp_none("drn0");
    cyc(1'b0, 32'h0, 1'b1, 32'hD0000003);  exp_word("drn1", 32'hD0000002);
    cyc(1'b0, 32'h0, 1'b1, 32'hD0000004);  exp_word("drn2", 32'hC0000003);
    cyc(1'b0, 32'h0, 1'b1, 32'hD0000005);  exp_word("drn3", 32'hD0000003);
    idle();                                exp_word("drn4", 32'hC0000004);
    idle();                                exp_word("drn5", 32'hD0000004);
    idle();                                exp_word("drn6", 32'hC0000005);
    idle();                                exp_word("drn7", 32'hD0000005);
    idle();                                exp_word("drn8", 32'hC0000006);
    idle();                                exp_none("drn9");
    check("drn9.ovf", 32'(overflow), 32'd1);

    // ---- 5: reset mid-stream with three words buffered -------------------
    // FSM is waiting on lane 1, so lane 0 words pile up in FIFO0.
    cyc(1'b1, 32'hE0000001, 1'b0, 32'h0);  exp_none("buf1");
    cyc(1'b1, 32'hE0000002, 1'b0, 32'h0);  exp_none("buf2");
    cyc(1'b1, 32'hE0000003, 1'b0, 32'h0);  exp_none("buf3");
    valid_0 = 1'b0;
    reset   = 1'b1;
    #1;
    check("arst.dat", data_out, 32'h0);
    check("arst.ovf", 32'(overflow), 32'd0);
    idle();                                exp_none("rsth");
    reset = 1'b0;
    cyc(1'b0, 32'h0, 1'b1, 32'hF0000001);  exp_none("post0");
    check("post0.dat", data_out, 32'h0);
    cyc(1'b1, 32'h90000001, 1'b0, 32'h0);  exp_none("post1");  // FIFO0 was emptied
    idle();                                exp_word("post2", 32'h90000001);
    idle();                                exp_word("post3", 32'hF0000001);
    idle();                                exp_none("post4");
    check("post4.ovf", 32'(overflow), 32'd0);

`ifdef UNSTRIPING_CNT_EN
    // ---- 6: word counter wraps (CNT_W = 4) -------------------------------
    reset = 1'b1;
    idle();
    check("cnt.rst", 32'(word_count), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 17; k++) begin
      if (k % 2 == 0) cyc(1'b1, 32'h70000000 + 32'(k), 1'b0, 32'h0);
      else            cyc(1'b0, 32'h0, 1'b1, 32'h70000000 + 32'(k));
      // After step k, k words have been emitted.
      check("cnt.run", 32'(word_count), 32'(k % 16));
    end
    idle();
    exp_word("cnt.last", 32'h70000010);
    check("cnt.end", 32'(word_count), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
